// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_issue_ctrl
//  Description : Sequencing controller between the execute-stage issue logic
//                and an iterative multiplier. It accepts one MUL at a time,
//                pulses the multiplier start, stalls upstream until the
//                result returns and presents a one-cycle writeback. It also
//                handles flushes mid-operation and a watchdog timeout.
//  Options     : MUL_RESULT_CACHE_EN - when defined, the last completed
//                {rs1, rs2, result} is kept. A matching request then
//                completes in one cycle without starting the multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64,
    parameter int RD_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    input  logic [WIDTH-1:0] req_rs1_i,
    input  logic [WIDTH-1:0] req_rs2_i,
    input  logic [RD_W-1:0]  req_rd_i,
    output logic             req_ready_o,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             mul_start_o,
    output logic [WIDTH-1:0] mul_rs1_o,
    output logic [WIDTH-1:0] mul_rs2_o,
    input  logic [WIDTH-1:0] mul_result_i,
    input  logic             mul_valid_i,
    input  logic             mul_busy_i,
    output logic             wb_valid_o,
    output logic [RD_W-1:0]  wb_rd_o,
    output logic [WIDTH-1:0] wb_data_o,
    output logic             err_o
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    logic [WIDTH-1:0]   op_rs1_q;
    logic [WIDTH-1:0]   op_rs2_q;
    logic [RD_W-1:0]    wb_rd_q;
    logic [WIDTH-1:0]   wb_data_q;
    logic               mul_start_q;
    logic               err_q;

    logic               w_accept;
    logic               w_hit;
    logic [WIDTH-1:0]   w_hit_data;
    logic               w_timeout;

    // A request is taken only from IDLE, never while killed or while the
    // multiplier is still busy with something else.
    assign w_accept  = (state_q == c_IDLE) && req_valid_i && !flush_i && !mul_busy_i;
    assign w_timeout = (cnt_q == c_CNT_LAST);

`ifdef MUL_RESULT_CACHE_EN
    logic             cache_valid_q;
    logic [WIDTH-1:0] cache_rs1_q;
    logic [WIDTH-1:0] cache_rs2_q;
    logic [WIDTH-1:0] cache_res_q;

    assign w_hit      = cache_valid_q && (req_rs1_i == cache_rs1_q) && (req_rs2_i == cache_rs2_q);
    assign w_hit_data = cache_res_q;

    // Remember the last good result; any kill or timeout invalidates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_q <= 1'b0;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_res_q   <= '0;
        end else if (flush_i && (state_q != c_IDLE)) begin
            cache_valid_q <= 1'b0;
        end else if ((state_q == c_WAIT) && mul_valid_i) begin
            cache_valid_q <= 1'b1;
            cache_rs1_q   <= op_rs1_q;
            cache_rs2_q   <= op_rs2_q;
            cache_res_q   <= mul_result_i;
        end else if (((state_q == c_WAIT) || (state_q == c_DRAIN)) && w_timeout) begin
            cache_valid_q <= 1'b0;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // State register; reset lands in IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and watchdog counter; in WAIT a flush beats a result.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    state_d = w_hit ? c_DONE : c_ISSUE;
                end
            end
            c_ISSUE: begin
                // The start pulse is already out, so a kill here must drain.
                state_d = flush_i ? c_DRAIN : c_WAIT;
            end
            c_WAIT: begin
                cnt_d = cnt_q + c_CNT_ONE;
                if (flush_i) begin
                    // A result arriving with the kill leaves nothing to drain.
                    state_d = mul_valid_i ? c_IDLE : c_DRAIN;
                    cnt_d   = '0;
                end else if (mul_valid_i || w_timeout) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            c_DRAIN: begin
                cnt_d = cnt_q + c_CNT_ONE;
                if (mul_valid_i || w_timeout) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Handshake, stall and writeback strobe decoded from the current state.
    always_comb begin
        stall_o    = 1'b0;
        wb_valid_o = 1'b0;
        case (state_q)
            c_IDLE:  stall_o = req_valid_i && !flush_i && !(w_accept && w_hit);
            c_ISSUE: stall_o = 1'b1;
            c_WAIT:  stall_o = 1'b1;
            c_DONE:  wb_valid_o = !flush_i;
            c_DRAIN: stall_o = req_valid_i;
            default: stall_o = 1'b0;
        endcase
    end

    assign req_ready_o = w_accept;

    // Operand latches, start pulse, writeback payload and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_start_q <= 1'b0;
            op_rs1_q    <= '0;
            op_rs2_q    <= '0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            // Only an accept can raise start, and accepts happen only in
            // IDLE, so the pulse can never repeat on the following cycle.
            mul_start_q <= w_accept && !w_hit;
            if (w_accept) begin
                op_rs1_q <= req_rs1_i;
                op_rs2_q <= req_rs2_i;
                wb_rd_q  <= req_rd_i;
                if (w_hit) begin
                    wb_data_q <= w_hit_data;
                end
            end
            if ((state_q == c_WAIT) && !flush_i) begin
                if (mul_valid_i) begin
                    wb_data_q <= mul_result_i;
                end else if (w_timeout) begin
                    wb_data_q <= '0;
                    err_q     <= 1'b1;
                end
            end
            if ((state_q == c_DRAIN) && !mul_valid_i && w_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mul_start_o = mul_start_q;
    assign mul_rs1_o   = op_rs1_q;
    assign mul_rs2_o   = op_rs2_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire
